secuenciador_ventana_filtro: RTL
================================

Name: secuenciador_ventana_filtro

Overview:
Scheduler that sequences a KxK sliding window across an ANCHO_IMG x ALTO_IMG frame.
- Accepts pixels from the source with a valid/ready handshake.
- Drives line-buffer write and row-rotation strobes.
- Runs the fill phase (first K-1 rows), then the processing phase, where it emits one window-valid per pixel at column >= K-1.
- Sits between the pixel source, the row-buffer bank (row-update FSM) and the filter datapath.

Parameters:
ANCHO_IMG, 640, pixels per row (>= K)
ALTO_IMG, 480, rows per frame (>= K)
K, 3, window side; fill phase lasts K-1 rows

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
iniciar  in  1  start-of-frame pulse; honoured only in E_REPOSO
pixel_valido  in  1  source has a pixel
pixel_listo  out  1  block accepts pixel this cycle
escribir_pixel  out  1  line-buffer write enable (= pixel_valido & pixel_listo)
columna  out  clog2(ANCHO_IMG)  column of pixel being accepted
fila  out  clog2(ALTO_IMG)  row of pixel being accepted
rotar_filas  out  1  one-cycle pulse: row completed, rotate line buffers
ventana_valida  out  1  window ready for the filter datapath
ventana_lista  in  1  datapath consumes window
ocupado  out  1  high outside E_REPOSO
frame_terminado  out  1  one-cycle pulse at end of frame

Behaviour:
Reset values:
- E_REPOSO; columna = fila = 0.
- pixel_listo, rotar_filas, ventana_valida, frame_terminado, ocupado all 0.

Handshakes:
- Acceptance = pixel_valido & pixel_listo. Counters advance only on acceptance.
- Window handshake completes on ventana_valida & ventana_lista.

States:
- E_REPOSO: pixel_listo = 0. On iniciar -> E_LLENADO; counters cleared.
- E_LLENADO: pixel_listo = 1. Accepting pixel (ANCHO_IMG-1, K-2) -> E_PROCESO.
- E_PROCESO: pixel_listo = ~(ventana_valida & ~ventana_lista). A stalled window blocks new pixels; the same cycle the window is consumed, a new pixel may be accepted. Accepting pixel (ANCHO_IMG-1, ALTO_IMG-1) -> E_FIN.
- E_FIN: single cycle. frame_terminado = 1, pixel_listo = 0. Then -> E_REPOSO.

Counters:
- columna wraps ANCHO_IMG-1 -> 0 on acceptance; fila increments on that wrap.
- fila wraps to 0 at end of frame.

rotar_filas:
- Registered; asserted the cycle after acceptance of any column ANCHO_IMG-1, including the last row of the frame.

ventana_valida:
- Registered; set the cycle after acceptance in E_PROCESO with columna >= K-1.
- Held until ventana_lista. Cleared after the handshake unless a new qualifying pixel is accepted in the same cycle, in which case it stays 1.
- Never asserted for columns 0..K-2 or during E_LLENADO.
- Last window may still be pending in E_FIN. E_FIN holds (frame_terminado stays 0) until that window is consumed; frame_terminado pulses on the consuming cycle.

Other rules:
- Windows per frame = (ALTO_IMG-K+1)*(ANCHO_IMG-K+1).
- iniciar outside E_REPOSO is ignored.
- reset mid-frame: immediate return to reset values; pending window dropped.

Optional Feature:
Macro SECUENCIADOR_CICLOS_ESPERA_EN.
- Defined: extra output ciclos_espera [15:0]. Counts cycles with ventana_valida & ~ventana_lista; saturates at 16'hFFFF; cleared by reset and by accepted iniciar.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
Shared package pkg_filtros holds:
- state localparams E_REPOSO, E_LLENADO, E_PROCESO, E_FIN;
- width helpers (clog2-based ANCHO_COL / ANCHO_FILA).

One natural sub-module: contador_modular (parameter MODULO; enable, wrap-pulse output), instantiated for columna and fila.

Test Plan (ANCHO_IMG=8, ALTO_IMG=5, K=3):
- Fill, source always valid: iniciar, then 16 pixels accepted. rotar_filas pulses after pixels 8 and 16; no ventana_valida; state reaches E_PROCESO.
- Full frame, ventana_lista tied 1: 40 pixels accepted. Exactly 18 ventana_valida cycles (cols 2..7 of rows 2..4). 5 rotar_filas pulses; frame_terminado one cycle after pixel 40; then ocupado = 0.
- Backpressure: ventana_lista = 0 for 4 cycles at (col 3, row 2). ventana_valida held, pixel_listo = 0 for those cycles, no pixel lost, window count still 18. With macro: ciclos_espera = 4.
- Source bubbles: pixel_valido toggles 1/0. Counters advance only on accepted pixels; final counts match the continuous case.
- Reset at (col 5, row 3): next cycle all outputs at reset values. A following iniciar plus a full frame gives 18 windows.
- iniciar asserted during E_PROCESO: ignored. Counters, state and window count unaffected.

Source files
------------

// File: rtl/pkg_filtros.sv
// Shared definitions for the sliding-window filter scheduler:
// FSM state encodings and counter width helpers.
package pkg_filtros;

    localparam logic [1:0] E_REPOSO  = 2'd0;
    localparam logic [1:0] E_LLENADO = 2'd1;
    localparam logic [1:0] E_PROCESO = 2'd2;
    localparam logic [1:0] E_FIN     = 2'd3;

    // Never returns 0 so a degenerate size still yields a legal vector.
    function automatic int ancho_de(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ANCHO_COL  = ancho_de(640);
    localparam int ANCHO_FILA = ancho_de(480);

endpackage

// File: rtl/secuenciador_ventana_filtro_contador.sv
// Modulo-N counter with synchronous clear and a combinational
// wrap pulse that fires on the enabled cycle leaving MODULO-1.
module contador_modular #(
    parameter int MODULO = 8,
    parameter int ANCHO  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             borrar_i,
    input  logic             habilitar_i,
    output logic [ANCHO-1:0] cuenta_o,
    output logic             envuelve_o
);

    localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(MODULO - 1);

    logic [ANCHO-1:0] cuenta_q, cuenta_d;

    assign cuenta_o   = cuenta_q;
    assign envuelve_o = habilitar_i & (cuenta_q == ULTIMO);

    always_comb begin
        cuenta_d = cuenta_q;
        if (borrar_i)
            cuenta_d = '0;
        else if (habilitar_i)
            cuenta_d = envuelve_o ? '0 : cuenta_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cuenta_q <= '0;
        else       cuenta_q <= cuenta_d;
    end

endmodule

// File: rtl/secuenciador_ventana_filtro.sv
// KxK sliding-window scheduler: fill phase, processing phase, end of frame.
// Optional stall-cycle counter output under SECUENCIADOR_CICLOS_ESPERA_EN.
module secuenciador_ventana_filtro
    import pkg_filtros::*;
#(
    parameter int ANCHO_IMG = 640,
    parameter int ALTO_IMG  = 480,
    parameter int K         = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic                           pixel_valido,
    output logic                           pixel_listo,
    output logic                           escribir_pixel,
    output logic [ancho_de(ANCHO_IMG)-1:0] columna,
    output logic [ancho_de(ALTO_IMG)-1:0]  fila,
    output logic                           rotar_filas,
    output logic                           ventana_valida,
    input  logic                           ventana_lista,
    output logic                           ocupado,
`ifdef SECUENCIADOR_CICLOS_ESPERA_EN
    output logic [15:0]                    ciclos_espera,
`endif
    output logic                           frame_terminado
);

    localparam int AC = ancho_de(ANCHO_IMG);
    localparam int AF = ancho_de(ALTO_IMG);

    logic [1:0] estado_q, estado_d;
    logic       rotar_q, ventana_q, ventana_d;
    logic       acepta, arranca, fin_linea, fin_frame;
    logic       fin_llenado, califica, consumida;

    assign acepta      = pixel_valido & pixel_listo;
    assign arranca     = (estado_q == E_REPOSO) & iniciar;
    assign consumida   = ventana_q & ventana_lista;
    assign fin_llenado = fin_linea & (fila == AF'(K - 2));
    assign califica    = acepta & (estado_q == E_PROCESO)
                       & (columna >= AC'(K - 1));

    contador_modular #(.MODULO(ANCHO_IMG), .ANCHO(AC)) u_col (
        .clk        (clk),
        .reset      (reset),
        .borrar_i   (arranca),
        .habilitar_i(acepta),
        .cuenta_o   (columna),
        .envuelve_o (fin_linea)
    );

    contador_modular #(.MODULO(ALTO_IMG), .ANCHO(AF)) u_fila (
        .clk        (clk),
        .reset      (reset),
        .borrar_i   (arranca),
        .habilitar_i(fin_linea),
        .cuenta_o   (fila),
        .envuelve_o (fin_frame)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= E_REPOSO;
            rotar_q   <= 1'b0;
            ventana_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            rotar_q   <= fin_linea;
            ventana_q <= ventana_d;
        end
    end

    // A new qualifying pixel wins over a same-cycle consumption.
    always_comb begin
        ventana_d = ventana_q;
        if (califica)
            ventana_d = 1'b1;
        else if (consumida)
            ventana_d = 1'b0;
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            E_REPOSO:  if (iniciar)     estado_d = E_LLENADO;
            E_LLENADO: if (fin_llenado) estado_d = E_PROCESO;
            E_PROCESO: if (fin_frame)   estado_d = E_FIN;
            E_FIN:     if (!ventana_q || ventana_lista)
                           estado_d = E_REPOSO;
            default:   estado_d = E_REPOSO;
        endcase
    end

    always_comb begin
        pixel_listo     = 1'b0;
        frame_terminado = 1'b0;
        ocupado         = 1'b1;
        unique case (estado_q)
            E_REPOSO:  ocupado = 1'b0;
            E_LLENADO: pixel_listo = 1'b1;
            E_PROCESO: pixel_listo = ~(ventana_q & ~ventana_lista);
            E_FIN:     frame_terminado = ~ventana_q | ventana_lista;
            default:   ocupado = 1'b0;
        endcase
    end

    assign escribir_pixel = acepta;
    assign rotar_filas    = rotar_q;
    assign ventana_valida = ventana_q;

`ifdef SECUENCIADOR_CICLOS_ESPERA_EN
    logic [15:0] espera_q, espera_d;

    always_comb begin
        espera_d = espera_q;
        if (arranca)
            espera_d = '0;
        else if (ventana_q && !ventana_lista && espera_q != 16'hFFFF)
            espera_d = espera_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) espera_q <= '0;
        else       espera_q <= espera_d;
    end

    assign ciclos_espera = espera_q;
`endif

endmodule
